// File: rtl/vga_pkg.sv
// vga_pkg: shared constants for the VGA raster timing generator.
//   - Reset-default 640x480@60 timing values.
//   - Field indices of the packed {max,sp,fp,size} timing words (cfg_h/cfg_v).
//   - Flag-bit indices for the sync/valid/sof bundle carried by the delay line.
//   - timing_ok(): legality check applied to every written timing word.
package vga_pkg;

  localparam int DEF_HSIZE = 640;
  localparam int DEF_HFP   = 656;
  localparam int DEF_HSP   = 752;
  localparam int DEF_HMAX  = 800;
  localparam int DEF_VSIZE = 480;
  localparam int DEF_VFP   = 490;
  localparam int DEF_VSP   = 492;
  localparam int DEF_VMAX  = 525;

  // Field index inside a timing word; field i occupies bits [i*W +: W].
  localparam int CFG_SIZE_IDX = 0;
  localparam int CFG_FP_IDX   = 1;
  localparam int CFG_SP_IDX   = 2;
  localparam int CFG_MAX_IDX  = 3;

  // Deepest supported sync/valid alignment delay, in pixel strobes.
  localparam int PIPE_DLY_MAX = 8;

  // Bit positions inside the 4-bit flag bundle.
  localparam int FLAG_HS = 0;
  localparam int FLAG_VS = 1;
  localparam int FLAG_VA = 2;
  localparam int FLAG_SO = 3;
  localparam int FLAG_W  = 4;

  // A timing axis is legal when the active region is non-empty, the sync
  // pulse is non-empty and sits after the active region, and the total
  // covers everything (minimum total of 2 keeps the counter wrapping).
  function automatic logic timing_ok(input logic [31:0] sz, input logic [31:0] fp,
                                     input logic [31:0] sp, input logic [31:0] mx);
    return (sz >= 32'd1) && (sz <= fp) && (fp < sp) && (sp <= mx) && (mx >= 32'd2);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: strobe-gated shift register used to align the sync/valid
// flags with a downstream pixel pipeline.
//   clk     in   system clock
//   rst_n   in   synchronous active-low reset, loads every stage with rst_val
//   ce      in   pixel strobe; the line shifts only when high
//   rst_val in   WIDTH  value loaded into every stage at reset
//   din     in   WIDTH  input word
//   dout    out  WIDTH  input delayed by DEPTH strobes (DEPTH=0: pass-through)
module vga_delay_line #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [WIDTH-1:0] rst_val,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_pass
    assign dout = din;
    // Clock/reset/strobe have no function without stages.
    logic unused_pass;
    assign unused_pass = &{1'b0, clk, rst_n, ce, rst_val};
  end else begin : g_shift
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
      for (int i = 0; i < DEPTH; i++) stage_d[i] = stage_q[i];
      if (ce) begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= rst_val;
      end else begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= stage_d[i];
      end
    end

    assign dout = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: runtime-programmable VGA raster timing generator.
//   clk, rst_n       clock, synchronous active-low reset
//   ce               pixel strobe; all state advances only when high
//   cfg_wr           one-cycle write of a pending timing set
//   cfg_h / cfg_v    {max,sp,fp,size} timing words
//   cfg_pending      a written timing set waits for the frame boundary
//   cfg_err          one-cycle pulse after a rejected write
//   hdata / vdata    current raster position (undelayed)
//   hsync/vsync/valid/sof  flags delayed by PIPE_DLY strobes (PIPE_DLY <= PIPE_DLY_MAX)
//   eol              undelayed, high while hdata == hmax-1
//   frame_cnt        completed frames, wrapping
//
// Handshake: cfg_wr is a single-cycle request with no ready; it is accepted
// (or rejected via cfg_err) in the cycle it is high, independent of ce.
// A new timing set only becomes active on the ce of the last pixel of a
// frame, so the counters never see a total smaller than their value.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int HWIDTH   = 12,
  parameter int VWIDTH   = 12,
  parameter int HSIZE    = DEF_HSIZE,
  parameter int HFP      = DEF_HFP,
  parameter int HSP      = DEF_HSP,
  parameter int HMAX     = DEF_HMAX,
  parameter int VSIZE    = DEF_VSIZE,
  parameter int VFP      = DEF_VFP,
  parameter int VSP      = DEF_VSP,
  parameter int VMAX     = DEF_VMAX,
  parameter int HSPP     = 1,
  parameter int VSPP     = 1,
  parameter int PIPE_DLY = 0,
  parameter int FCWIDTH  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ce,
  input  logic                cfg_wr,
  input  logic [4*HWIDTH-1:0] cfg_h,
  input  logic [4*VWIDTH-1:0] cfg_v,
  output logic                cfg_pending,
  output logic                cfg_err,
  output logic [HWIDTH-1:0]   hdata,
  output logic [VWIDTH-1:0]   vdata,
  output logic                hsync,
  output logic                vsync,
  output logic                valid,
  output logic                sof,
  output logic                eol,
  output logic [FCWIDTH-1:0]  frame_cnt
);

  localparam logic HS_ON = (HSPP != 0);
  localparam logic VS_ON = (VSPP != 0);

  // Field order matches CFG_*_IDX: size in the low slice, max in the high.
  localparam logic [4*HWIDTH-1:0] DEF_H = {HWIDTH'(HMAX), HWIDTH'(HSP), HWIDTH'(HFP), HWIDTH'(HSIZE)};
  localparam logic [4*VWIDTH-1:0] DEF_V = {VWIDTH'(VMAX), VWIDTH'(VSP), VWIDTH'(VFP), VWIDTH'(VSIZE)};

  logic [HWIDTH-1:0]   h_q, h_d;
  logic [VWIDTH-1:0]   v_q, v_d;
  logic [4*HWIDTH-1:0] act_h_q, act_h_d, pend_h_q, pend_h_d;
  logic [4*VWIDTH-1:0] act_v_q, act_v_d, pend_v_q, pend_v_d;
  logic                pend_q, pend_d;
  logic                err_q, err_d;
  logic [FCWIDTH-1:0]  fcnt_q, fcnt_d;

  logic [HWIDTH-1:0] hsize, hfp, hsp, hmax;
  logic [VWIDTH-1:0] vsize, vfp, vsp, vmax;
  logic              h_last, v_last, frame_end, wr_ok;
  logic [FLAG_W-1:0] flag_raw, flag_idle, flag_dly;

  assign hsize = act_h_q[CFG_SIZE_IDX*HWIDTH +: HWIDTH];
  assign hfp   = act_h_q[CFG_FP_IDX*HWIDTH   +: HWIDTH];
  assign hsp   = act_h_q[CFG_SP_IDX*HWIDTH   +: HWIDTH];
  assign hmax  = act_h_q[CFG_MAX_IDX*HWIDTH  +: HWIDTH];
  assign vsize = act_v_q[CFG_SIZE_IDX*VWIDTH +: VWIDTH];
  assign vfp   = act_v_q[CFG_FP_IDX*VWIDTH   +: VWIDTH];
  assign vsp   = act_v_q[CFG_SP_IDX*VWIDTH   +: VWIDTH];
  assign vmax  = act_v_q[CFG_MAX_IDX*VWIDTH  +: VWIDTH];

  assign h_last    = (h_q == hmax - HWIDTH'(1));
  assign v_last    = (v_q == vmax - VWIDTH'(1));
  assign frame_end = ce && h_last && v_last;

  assign wr_ok = cfg_wr
    && timing_ok(32'(cfg_h[CFG_SIZE_IDX*HWIDTH +: HWIDTH]), 32'(cfg_h[CFG_FP_IDX*HWIDTH +: HWIDTH]),
                 32'(cfg_h[CFG_SP_IDX*HWIDTH +: HWIDTH]),   32'(cfg_h[CFG_MAX_IDX*HWIDTH +: HWIDTH]))
    && timing_ok(32'(cfg_v[CFG_SIZE_IDX*VWIDTH +: VWIDTH]), 32'(cfg_v[CFG_FP_IDX*VWIDTH +: VWIDTH]),
                 32'(cfg_v[CFG_SP_IDX*VWIDTH +: VWIDTH]),   32'(cfg_v[CFG_MAX_IDX*VWIDTH +: VWIDTH]));

  always_comb begin
    h_d      = h_q;
    v_d      = v_q;
    act_h_d  = act_h_q;
    act_v_d  = act_v_q;
    pend_h_d = pend_h_q;
    pend_v_d = pend_v_q;
    pend_d   = pend_q;
    fcnt_d   = fcnt_q;
    err_d    = cfg_wr && !wr_ok;

    if (ce) begin
      if (h_last) begin
        h_d = '0;
        v_d = v_last ? '0 : v_q + VWIDTH'(1);
      end else begin
        h_d = h_q + HWIDTH'(1);
      end
    end

    // Only a set that was already pending before this cycle is applied;
    // a write landing on the same cycle is handled below and stays pending.
    if (frame_end) begin
      fcnt_d = fcnt_q + FCWIDTH'(1);
      if (pend_q) begin
        act_h_d = pend_h_q;
        act_v_d = pend_v_q;
        pend_d  = 1'b0;
      end
    end

    if (wr_ok) begin
      pend_h_d = cfg_h;
      pend_v_d = cfg_v;
      pend_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_q      <= '0;
      v_q      <= '0;
      act_h_q  <= DEF_H;
      act_v_q  <= DEF_V;
      pend_h_q <= DEF_H;
      pend_v_q <= DEF_V;
      pend_q   <= 1'b0;
      err_q    <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      act_h_q  <= act_h_d;
      act_v_q  <= act_v_d;
      pend_h_q <= pend_h_d;
      pend_v_q <= pend_v_d;
      pend_q   <= pend_d;
      err_q    <= err_d;
      fcnt_q   <= fcnt_d;
    end
  end

  always_comb begin
    flag_raw          = '0;
    flag_raw[FLAG_HS] = ((h_q >= hfp) && (h_q < hsp)) ? HS_ON : ~HS_ON;
    flag_raw[FLAG_VS] = ((v_q >= vfp) && (v_q < vsp)) ? VS_ON : ~VS_ON;
    flag_raw[FLAG_VA] = (h_q < hsize) && (v_q < vsize);
    flag_raw[FLAG_SO] = (h_q == '0) && (v_q == '0);

    flag_idle          = '0;
    flag_idle[FLAG_HS] = ~HS_ON;
    flag_idle[FLAG_VS] = ~VS_ON;
  end

  vga_delay_line #(
    .WIDTH(FLAG_W),
    .DEPTH(PIPE_DLY)
  ) u_dly (
    .clk    (clk),
    .rst_n  (rst_n),
    .ce     (ce),
    .rst_val(flag_idle),
    .din    (flag_raw),
    .dout   (flag_dly)
  );

  assign hsync       = flag_dly[FLAG_HS];
  assign vsync       = flag_dly[FLAG_VS];
  assign valid       = flag_dly[FLAG_VA];
  assign sof         = flag_dly[FLAG_SO];
  assign eol         = h_last;
  assign hdata       = h_q;
  assign vdata       = v_q;
  assign cfg_pending = pend_q;
  assign cfg_err     = err_q;
  assign frame_cnt   = fcnt_q;

endmodule
